mem_mmio: RTL and testbench
===========================

Name: mem_mmio

Overview:
- Memory subsystem that sits directly downstream of the multi-cycle CPU core.
- Consumes the core's adr, MemWrite and writedata; returns readdata combinationally within the same cycle, as the core's IR and data registers require.
- Contains a unified instruction/data RAM plus a small memory-mapped I/O window: LEDs, switches and a down-counting timer with an interrupt flag.

Parameters:
- RAM_AW, 10, RAM word-address width; RAM holds 2^RAM_AW 32-bit words at byte addresses 0 .. 4*2^RAM_AW-1.
- INIT_FILE, "", hex file loaded into RAM at elaboration; empty string means no preload.
- SW_W, 16, width of switch input and LED output.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- MemWrite  in  1  write strobe from the core.
- adr  in  32  byte address from the core; adr[1:0] ignored (word access only).
- writedata  in  32  store data from the core.
- readdata  out  32  read data, combinational from adr.
- sw  in  SW_W  board switches, sampled through a 2-flop synchronizer.
- led  out  SW_W  LED register.
- timer_irq  out  1  level output, equals the sticky expired flag.
- bus_err  out  1  registered flag, 1 for one cycle after any access to an unmapped address.

Behaviour:
- Address decode:
  - RAM when adr < 4*2^RAM_AW.
  - MMIO when adr[31:8] == 24'hFFFF00.
  - Everything else is unmapped.
- RAM:
  - Asynchronous read of word adr[RAM_AW+1:2].
  - Synchronous write on the clock edge when MemWrite=1.
  - Contents are not cleared by rst.
- MMIO registers (offset = adr[7:0]):
  - 0x00 LED: RW; bits above SW_W read 0.
  - 0x04 SW: RO; returns the synchronized switches, zero-extended.
  - 0x08 TCTRL: RW; bit0 EN, bit1 AUTO; other bits read 0.
  - 0x0C TLOAD: RW. A write also copies writedata into TCOUNT on the same edge.
  - 0x10 TCOUNT: RO.
  - 0x14 TSTAT: bit0 EXP, sticky. Writing 1 to bit0 clears it; writing 0 has no effect.
- Access rules:
  - Unmapped reads and reads of undefined MMIO offsets return 32'h0.
  - Writes to RO registers, undefined offsets or unmapped addresses are ignored.
- bus_err:
  - Set on the edge following a read or write to an unmapped address or an undefined MMIO offset.
  - Clears on the next edge unless another such access occurs.
  - Reads are counted only when the address is an unmapped data access. The core always drives adr, so a read counts only when MemWrite=1 or the address falls in the MMIO window with an undefined offset. This avoids false errors from idle adr values.
- Timer, evaluated each edge with EN=1:
  - TCOUNT != 0: TCOUNT <= TCOUNT-1.
  - TCOUNT == 0: EXP <= 1. If AUTO=1, TCOUNT <= TLOAD; otherwise EN <= 0 and TCOUNT stays at 0.
  - With EN=0, TCOUNT holds.
- Simultaneous events:
  - CPU write to TSTAT clear and expiry on the same edge: expiry wins, EXP=1.
  - CPU write to TCTRL and hardware EN clear on the same edge: CPU write wins.
  - CPU write to TLOAD while counting: TCOUNT takes the new value on that edge; no decrement that cycle.
- Reset values (rst=1 at an edge):
  - led=0, TCTRL=0, TLOAD=0, TCOUNT=0, EXP=0, timer_irq=0, bus_err=0, synchronizer flops=0.
  - readdata remains combinational.
  - Reset in the middle of a countdown abandons it immediately.
- Latency:
  - Reads take zero cycles.
  - Writes become visible on readdata in the cycle after the edge.
  - Switch changes appear on SW 2 edges after they are applied.

Decomposition:
- Shared package mem_map_pkg:
  - Constants MMIO_BASE=32'hFFFF0000 and offsets OFF_LED, OFF_SW, OFF_TCTRL, OFF_TLOAD, OFF_TCOUNT, OFF_TSTAT.
  - TCTRL bit indices EN_BIT, AUTO_BIT.
- One sub-module mmio_timer. It owns TCTRL, TLOAD, TCOUNT and EXP, with write-enable and data inputs, and outputs count, ctrl, exp.
- mem_mmio holds the decode logic, RAM, LED register, synchronizer and readdata mux.

Test Plan:
- RAM: write 32'hDEADBEEF to adr 0x40, then read adr 0x40 and adr 0x43 -> both return 32'hDEADBEEF; adr 0x44 is unchanged.
- One-shot timer:
  - Write TLOAD=3, then TCTRL=1 -> TCOUNT reads 3,2,1,0 on successive cycles.
  - Next edge sets EXP and timer_irq=1; TCTRL then reads 0 and TCOUNT stays 0.
- Auto-reload with clear race:
  - Set TLOAD=2, TCTRL=3 and let it expire; TCOUNT reloads to 2.
  - Write TSTAT=1 on the same edge as the next expiry -> EXP remains 1.
  - Write TSTAT=1 on a non-expiry edge -> EXP becomes 0.
- LED and switches: write LED=32'h1234ABCD -> led=16'hABCD. Set sw=16'h00F0 -> SW reads 0 for the first edge and 32'h000000F0 after 2 edges.
- Bus errors:
  - Write to 0x8000_0000 -> bus_err=1 for exactly one cycle; RAM and registers unchanged.
  - Read of offset 0x18 -> readdata=0 and bus_err pulses.
- Reset mid-count: with TLOAD=100 and EN=1, assert rst for one edge at TCOUNT=50 -> TCOUNT=0, EN=0, led=0, timer_irq=0; RAM word at 0x40 still holds its value.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Memory-map constants shared by the memory subsystem and its timer.
// MMIO window base, register byte offsets inside that window, and the
// bit positions of the timer control register.
package mem_map_pkg;

  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;

  localparam logic [7:0]  OFF_LED    = 8'h00;
  localparam logic [7:0]  OFF_SW     = 8'h04;
  localparam logic [7:0]  OFF_TCTRL  = 8'h08;
  localparam logic [7:0]  OFF_TLOAD  = 8'h0C;
  localparam logic [7:0]  OFF_TCOUNT = 8'h10;
  localparam logic [7:0]  OFF_TSTAT  = 8'h14;

  localparam int EN_BIT   = 0;
  localparam int AUTO_BIT = 1;

  // True for every word offset that has a register behind it.
  function automatic logic is_defined_off(input logic [7:0] off);
    return off inside {OFF_LED, OFF_SW, OFF_TCTRL, OFF_TLOAD, OFF_TCOUNT, OFF_TSTAT};
  endfunction

endpackage

// File: rtl/mem_mmio_if.sv
// Core-to-memory bus: write strobe, byte address, store data and the
// combinational read data returned in the same cycle.
//   master : the CPU core (drives MemWrite/adr/writedata)
//   slave  : the memory subsystem (drives readdata)
interface mem_mmio_if;
  logic        MemWrite;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output MemWrite, adr, writedata, input readdata);
  modport slave  (input MemWrite, adr, writedata, output readdata);
endinterface

// File: rtl/mmio_timer.sv
// Down-counting timer with sticky expiry flag.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   ctrl_we, load_we, stat_we  CPU write enables for TCTRL, TLOAD, TSTAT
//   wdata             CPU store data
//   count, load       current TCOUNT and TLOAD
//   ctrl              TCTRL {AUTO, EN}
//   exp               sticky expired flag (EXP)
module mmio_timer
  import mem_map_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_we,
  input  logic        load_we,
  input  logic        stat_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] load,
  output logic [1:0]  ctrl,
  output logic        exp
);

  logic [1:0]  ctrl_reg;
  logic [31:0] load_reg;
  logic [31:0] count_reg;
  logic        exp_reg;
  logic        en;
  logic        auto_reload;
  logic        expire;

  assign en          = ctrl_reg[EN_BIT];
  assign auto_reload = ctrl_reg[AUTO_BIT];
  assign expire      = en && (count_reg == 32'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_reg  <= '0;
      load_reg  <= '0;
      count_reg <= '0;
      exp_reg   <= 1'b0;
    end else begin
      // A CPU write to TCTRL overrides the one-shot EN auto-clear.
      if (ctrl_we)
        ctrl_reg <= wdata[1:0];
      else if (expire && !auto_reload)
        ctrl_reg[EN_BIT] <= 1'b0;

      if (load_we)
        load_reg <= wdata;

      // Loading TLOAD also reloads the counter and suppresses that
      // cycle's decrement/reload.
      if (load_we)
        count_reg <= wdata;
      else if (expire) begin
        if (auto_reload)
          count_reg <= load_reg;
      end else if (en)
        count_reg <= count_reg - 32'd1;

      // Expiry beats a simultaneous write-1-to-clear.
      if (expire)
        exp_reg <= 1'b1;
      else if (stat_we && wdata[0])
        exp_reg <= 1'b0;
    end
  end

  assign count = count_reg;
  assign load  = load_reg;
  assign ctrl  = ctrl_reg;
  assign exp   = exp_reg;

endmodule

// File: rtl/mem_mmio.sv
// Memory subsystem for the multi-cycle core: unified instruction/data RAM
// plus an MMIO window with LEDs, synchronized switches and a timer.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        core bus (slave side); readdata is combinational from adr
//   sw         board switches (asynchronous, synchronized internally)
//   led        LED register
//   timer_irq  sticky timer expiry flag
//   bus_err    one-cycle pulse after an access to an unmapped location
module mem_mmio
  import mem_map_pkg::*;
#(
  parameter int    RAM_AW    = 10,
  parameter string INIT_FILE = "",
  parameter int    SW_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  mem_mmio_if.slave       bus,
  input  logic [SW_W-1:0] sw,
  output logic [SW_W-1:0] led,
  output logic            timer_irq,
  output logic            bus_err
);

  localparam logic [32:0] RAM_BYTES = 33'(4) << RAM_AW;

  logic [31:0]       ram [2**RAM_AW];
  logic [RAM_AW-1:0] word_adr;
  logic              is_ram;
  logic              is_mmio;
  logic [7:0]        off;
  logic              off_ok;
  logic              wr_mmio;
  logic              bad_access;

  logic [SW_W-1:0]   led_reg;
  logic [SW_W-1:0]   sw_meta_reg;
  logic [SW_W-1:0]   sw_sync_reg;
  logic              bus_err_reg;

  logic [31:0]       t_count;
  logic [31:0]       t_load;
  logic [1:0]        t_ctrl;
  logic              t_exp;
  logic [31:0]       rd;

  assign word_adr = bus.adr[RAM_AW+1:2];
  assign is_ram   = {1'b0, bus.adr} < RAM_BYTES;
  assign is_mmio  = bus.adr[31:8] == MMIO_BASE[31:8];
  // Word access only: the low two address bits never select a register.
  assign off      = {bus.adr[7:2], 2'b00};
  assign off_ok   = is_defined_off(off);
  assign wr_mmio  = bus.MemWrite && is_mmio;

  // Idle cycles still drive some adr, so plain reads outside the map are
  // not errors; only stores there, or any touch of an MMIO hole, are.
  assign bad_access = (bus.MemWrite && !is_ram && !is_mmio) || (is_mmio && !off_ok);

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.MemWrite && is_ram)
      ram[word_adr] <= bus.writedata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg     <= '0;
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
      bus_err_reg <= 1'b0;
    end else begin
      sw_meta_reg <= sw;
      sw_sync_reg <= sw_meta_reg;
      bus_err_reg <= bad_access;
      if (wr_mmio && off == OFF_LED)
        led_reg <= bus.writedata[SW_W-1:0];
    end
  end

  mmio_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .ctrl_we (wr_mmio && off == OFF_TCTRL),
    .load_we (wr_mmio && off == OFF_TLOAD),
    .stat_we (wr_mmio && off == OFF_TSTAT),
    .wdata   (bus.writedata),
    .count   (t_count),
    .load    (t_load),
    .ctrl    (t_ctrl),
    .exp     (t_exp)
  );

  always_comb begin
    rd = '0;
    if (is_ram)
      rd = ram[word_adr];
    else if (is_mmio) begin
      case (off)
        OFF_LED:    rd[SW_W-1:0] = led_reg;
        OFF_SW:     rd[SW_W-1:0] = sw_sync_reg;
        OFF_TCTRL:  rd[1:0]      = t_ctrl;
        OFF_TLOAD:  rd           = t_load;
        OFF_TCOUNT: rd           = t_count;
        OFF_TSTAT:  rd[0]        = t_exp;
        default:    rd           = '0;
      endcase
    end
  end

  assign bus.readdata = rd;
  assign led          = led_reg;
  assign timer_irq    = t_exp;
  assign bus_err      = bus_err_reg;

endmodule

// File: tb/tb_mem_mmio.sv
// Scoreboard bench for mem_mmio: expectations are queued as stimulus is
// applied and popped when the matching output is observed.
module tb_mem_mmio;
  import mem_map_pkg::*;

  localparam int SW_W = 16;
  localparam logic [31:0] A_LED    = MMIO_BASE + 32'(OFF_LED);
  localparam logic [31:0] A_SW     = MMIO_BASE + 32'(OFF_SW);
  localparam logic [31:0] A_TCTRL  = MMIO_BASE + 32'(OFF_TCTRL);
  localparam logic [31:0] A_TLOAD  = MMIO_BASE + 32'(OFF_TLOAD);
  localparam logic [31:0] A_TCOUNT = MMIO_BASE + 32'(OFF_TCOUNT);
  localparam logic [31:0] A_TSTAT  = MMIO_BASE + 32'(OFF_TSTAT);

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [SW_W-1:0] sw  = '0;
  logic [SW_W-1:0] led;
  logic            timer_irq;
  logic            bus_err;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_mmio_if bus ();

  mem_mmio #(.RAM_AW(10), .INIT_FILE(""), .SW_W(SW_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sw        (sw),
    .led       (led),
    .timer_irq (timer_irq),
    .bus_err   (bus_err)
  );

  always #10 clk = ~clk;

  // Drive one store across a rising edge; returns just after the next
  // falling edge with the bus idle.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.MemWrite  = 1'b1;
    bus.adr       = a;
    bus.writedata = d;
    @(negedge clk);
    #1;
    bus.MemWrite  = 1'b0;
    bus.adr       = 32'h0;
    bus.writedata = 32'h0;
  endtask

  task automatic rd_at(input logic [31:0] a);
    bus.MemWrite = 1'b0;
    bus.adr      = a;
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] a_tab [6];
    exp_t e;
    logic [31:0] obs;
    a_tab = '{A_LED, A_TCTRL, A_TLOAD, A_TCOUNT, A_TSTAT, A_SW};
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    sb.push_back('{"reset_outputs", 32'h0});
    obs = {14'h0, led, timer_irq, bus_err};
    e = sb.pop_front();
    n_tests++;
    if (obs !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
    end
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{$sformatf("reset_reg_%h", a_tab[i]), 32'h0});
      rd_at(a_tab[i]);
      e = sb.pop_front();
      n_tests++;
      if (bus.readdata !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", e.name, bus.readdata, e.val);
      end
    end
  endtask

  task automatic test_ram;
    logic [31:0] a_tab [3];
    logic [31:0] d_tab [3];
    exp_t e;
    a_tab = '{32'h40, 32'h43, 32'h44};
    d_tab = '{32'hDEADBEEF, 32'hDEADBEEF, 32'h11111111};
    wr(32'h44, 32'h11111111);
    wr(32'h40, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{$sformatf("ram_rd_%h", a_tab[i]), d_tab[i]});
      rd_at(a_tab[i]);
      e = sb.pop_front();
      n_tests++;
      if (bus.readdata !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", e.name, bus.readdata, e.val);
      end
    end
  endtask

  task automatic test_oneshot;
    exp_t e;
    logic [31:0] obs;
    wr(A_TLOAD, 32'd3);
    wr(A_TCTRL, 32'd1);
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{$sformatf("oneshot_count_%0d", i), 32'(3 - i)});
      rd_at(A_TCOUNT);
      e = sb.pop_front();
      n_tests++;
      if (bus.readdata !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", e.name, bus.readdata, e.val);
      end
      tick(1);
    end
    // Expiry edge has passed: irq set, EN cleared. One more edge: count holds.
    sb.push_back('{"oneshot_irq", 32'h1});
    sb.push_back('{"oneshot_tctrl", 32'h0});
    sb.push_back('{"oneshot_count_hold", 32'h0});
    obs = 32'(timer_irq);
    e = sb.pop_front();
    n_tests++;
    if (obs !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
    end
    rd_at(A_TCTRL);
    e = sb.pop_front();
    n_tests++;
    if (bus.readdata !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, bus.readdata, e.val);
    end
    tick(1);
    rd_at(A_TCOUNT);
    e = sb.pop_front();
    n_tests++;
    if (bus.readdata !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, bus.readdata, e.val);
    end
    // Writing 0 to TSTAT must not clear; writing 1 must.
    wr(A_TSTAT, 32'h0);
    sb.push_back('{"tstat_write0_keeps", 32'h1});
    obs = 32'(timer_irq);
    e = sb.pop_front();
    n_tests++;
    if (obs !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
    end
    wr(A_TSTAT, 32'h1);
    sb.push_back('{"tstat_write1_clears", 32'h0});
    obs = 32'(timer_irq);
    e = sb.pop_front();
    n_tests++;
    if (obs !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
    end
  endtask

  task automatic test_auto_reload;
    logic [31:0] c_tab [6];
    logic [31:0] i_tab [6];
    exp_t e;
    logic [31:0] obs;
    c_tab = '{32'd2, 32'd1, 32'd0, 32'd2, 32'd1, 32'd0};
    i_tab = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1};
    wr(A_TLOAD, 32'd2);
    wr(A_TCTRL, 32'd3);
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{$sformatf("auto_count_%0d", i), c_tab[i]});
      sb.push_back('{$sformatf("auto_irq_%0d", i), i_tab[i]});
      rd_at(A_TCOUNT);
      e = sb.pop_front();
      n_tests++;
      if (bus.readdata !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", e.name, bus.readdata, e.val);
      end
      obs = 32'(timer_irq);
      e = sb.pop_front();
      n_tests++;
      if (obs !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
      end
      if (i < 5) tick(1);
    end
    // Clear lands on an expiry edge: expiry wins, counter reloads.
    wr(A_TSTAT, 32'h1);
    sb.push_back('{"race_irq_kept", 32'h1});
    sb.push_back('{"race_reload", 32'd2});
    obs = 32'(timer_irq);
    e = sb.pop_front();
    n_tests++;
    if (obs !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
    end
    rd_at(A_TCOUNT);
    e = sb.pop_front();
    n_tests++;
    if (bus.readdata !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, bus.readdata, e.val);
    end
    // Clear on a plain decrement edge takes effect.
    wr(A_TSTAT, 32'h1);
    sb.push_back('{"clear_irq", 32'h0});
    obs = 32'(timer_irq);
    e = sb.pop_front();
    n_tests++;
    if (obs !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
    end
    wr(A_TCTRL, 32'h0);
    sb.push_back('{"tload_readback", 32'd2});
    rd_at(A_TLOAD);
    e = sb.pop_front();
    n_tests++;
    if (bus.readdata !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, bus.readdata, e.val);
    end
  endtask

  task automatic test_led_sw;
    logic [31:0] s_tab [3];
    exp_t e;
    logic [31:0] obs;
    s_tab = '{32'h0, 32'h0, 32'h000000F0};
    wr(A_LED, 32'h1234ABCD);
    sb.push_back('{"led_port", 32'h0000ABCD});
    sb.push_back('{"led_readback", 32'h0000ABCD});
    obs = 32'(led);
    e = sb.pop_front();
    n_tests++;
    if (obs !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
    end
    rd_at(A_LED);
    e = sb.pop_front();
    n_tests++;
    if (bus.readdata !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, bus.readdata, e.val);
    end
    sw = 16'h00F0;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{$sformatf("sw_sync_edge_%0d", i), s_tab[i]});
      rd_at(A_SW);
      e = sb.pop_front();
      n_tests++;
      if (bus.readdata !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", e.name, bus.readdata, e.val);
      end
      if (i < 2) tick(1);
    end
  endtask

  task automatic test_bus_err;
    exp_t e;
    logic [31:0] obs;
    wr(32'h8000_0000, 32'hCAFEF00D);
    sb.push_back('{"berr_write_set", 32'h1});
    obs = 32'(bus_err);
    e = sb.pop_front();
    n_tests++;
    if (obs !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
    end
    tick(1);
    sb.push_back('{"berr_one_cycle", 32'h0});
    obs = 32'(bus_err);
    e = sb.pop_front();
    n_tests++;
    if (obs !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
    end
    // Plain read of an unmapped address: zero data, no error.
    sb.push_back('{"unmapped_rd_zero", 32'h0});
    sb.push_back('{"unmapped_rd_no_berr", 32'h0});
    rd_at(32'h8000_0000);
    e = sb.pop_front();
    n_tests++;
    if (bus.readdata !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, bus.readdata, e.val);
    end
    tick(1);
    obs = 32'(bus_err);
    e = sb.pop_front();
    n_tests++;
    if (obs !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
    end
    // Ignored writes: unmapped store did not alias into RAM/LED; RO regs hold.
    wr(A_SW, 32'hFFFF_FFFF);
    wr(A_TCOUNT, 32'h0000_0055);
    sb.push_back('{"ram_after_berr", 32'hDEADBEEF});
    sb.push_back('{"led_after_berr", 32'h0000ABCD});
    sb.push_back('{"sw_ro", 32'h000000F0});
    sb.push_back('{"tcount_ro", 32'h0});
    rd_at(32'h40);
    e = sb.pop_front();
    n_tests++;
    if (bus.readdata !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, bus.readdata, e.val);
    end
    rd_at(A_LED);
    e = sb.pop_front();
    n_tests++;
    if (bus.readdata !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, bus.readdata, e.val);
    end
    rd_at(A_SW);
    e = sb.pop_front();
    n_tests++;
    if (bus.readdata !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, bus.readdata, e.val);
    end
    rd_at(A_TCOUNT);
    e = sb.pop_front();
    n_tests++;
    if (bus.readdata !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, bus.readdata, e.val);
    end
    // Read of an MMIO hole: zero data and an error pulse.
    sb.push_back('{"hole_rd_zero", 32'h0});
    sb.push_back('{"hole_rd_berr", 32'h1});
    sb.push_back('{"hole_berr_clears", 32'h0});
    rd_at(MMIO_BASE + 32'h18);
    e = sb.pop_front();
    n_tests++;
    if (bus.readdata !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, bus.readdata, e.val);
    end
    tick(1);
    obs = 32'(bus_err);
    e = sb.pop_front();
    n_tests++;
    if (obs !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
    end
    rd_at(A_LED);
    tick(1);
    obs = 32'(bus_err);
    e = sb.pop_front();
    n_tests++;
    if (obs !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
    end
  endtask

  task automatic test_reset_mid_count;
    logic [31:0] a_tab [5];
    logic [31:0] d_tab [5];
    exp_t e;
    logic [31:0] obs;
    a_tab = '{A_TCOUNT, A_TCTRL, A_SW, A_LED, 32'h40};
    d_tab = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF};
    wr(A_TLOAD, 32'd100);
    wr(A_TCTRL, 32'd1);
    tick(50);
    sb.push_back('{"midcount_50", 32'd50});
    rd_at(A_TCOUNT);
    e = sb.pop_front();
    n_tests++;
    if (bus.readdata !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, bus.readdata, e.val);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    sb.push_back('{"midrst_outputs", 32'h0});
    obs = {15'h0, led, timer_irq};
    e = sb.pop_front();
    n_tests++;
    if (obs !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
    end
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{$sformatf("midrst_rd_%h", a_tab[i]), d_tab[i]});
      rd_at(a_tab[i]);
      e = sb.pop_front();
      n_tests++;
      if (bus.readdata !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", e.name, bus.readdata, e.val);
      end
    end
    tick(1);
    sb.push_back('{"midrst_count_stays", 32'h0});
    rd_at(A_TCOUNT);
    e = sb.pop_front();
    n_tests++;
    if (bus.readdata !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", e.name, bus.readdata, e.val);
    end
  endtask

  initial begin
    bus.MemWrite  = 1'b0;
    bus.adr       = 32'h0;
    bus.writedata = 32'h0;
    test_reset();
    test_ram();
    test_oneshot();
    test_auto_reload();
    test_led_sw();
    test_bus_err();
    test_reset_mid_count();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
